// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: a shared microsecond timebase drives one
// comparator per channel; new positions are held in shadow registers until the frame boundary.
module servo_pwm_array #(
  parameter int unsigned   CH        = 3,
  parameter int unsigned   IN_W      = 10,
  parameter int unsigned   CLK_HZ    = 100_000_000,
  parameter int unsigned   FRAME_US  = 20000,
  parameter int unsigned   BASE_US   = 1000,
  parameter int unsigned   MIN_US    = 1000,
  parameter int unsigned   MAX_US    = 2000,
  parameter int unsigned   CENTER_US = 1500,
  parameter int unsigned   SLEW_US   = 0,
  parameter logic [CH-1:0] INV_MASK  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH*IN_W-1:0] pos_in,
  input  logic               pos_valid,
  input  logic               enable,
  output logic [CH-1:0]      pwm,
  output logic               frame_start
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  // One guard bit above the widest operand keeps BASE_US + code from wrapping before the clamp.
  localparam int unsigned SW  = max2(max2(IN_W, $clog2(MAX_US + 1)), $clog2(BASE_US + 1)) + 1;
  localparam int unsigned MW  = max2(CW, SW);

  logic [PW-1:0] presc;
  logic [CW-1:0] us_cnt;
  logic          us_tick_c;
  logic          commit_c;
  logic [SW-1:0] shadow     [CH];
  logic [SW-1:0] width      [CH];
  logic [SW-1:0] load_val   [CH];
  logic [SW-1:0] width_next [CH];

  assign us_tick_c = (presc == PW'(DIV - 1));
  assign commit_c  = us_tick_c && (us_cnt == CW'(FRAME_US - 1));

  // Offset, optional mirror and clamp of each incoming position code.
  always_comb begin
    logic [IN_W-1:0] code;
    logic [SW-1:0]   sum;
    load_val = '{default: '0};
    code     = '0;
    sum      = '0;
    for (int i = 0; i < CH; i++) begin
      code = pos_in[i*IN_W +: IN_W];
      if (INV_MASK[i]) code = ~code;
      sum = SW'(BASE_US) + SW'(code);
      if (sum < SW'(MIN_US))      load_val[i] = SW'(MIN_US);
      else if (sum > SW'(MAX_US)) load_val[i] = SW'(MAX_US);
      else                        load_val[i] = sum;
    end
  end

  // Slew-limited step of each width toward its shadow target.
  always_comb begin
    logic [SW-1:0] diff;
    width_next = width;
    diff       = '0;
    for (int i = 0; i < CH; i++) begin
      diff = (shadow[i] >= width[i]) ? (shadow[i] - width[i]) : (width[i] - shadow[i]);
      if ((SLEW_US == 0) || (32'(diff) <= SLEW_US)) width_next[i] = shadow[i];
      else if (shadow[i] > width[i])                width_next[i] = width[i] + SW'(SLEW_US);
      else                                          width_next[i] = width[i] - SW'(SLEW_US);
    end
  end

  // Timebase, shadow/width registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      us_cnt      <= '0;
      pwm         <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= SW'(CENTER_US);
        width[i]  <= SW'(CENTER_US);
      end
    end else begin
      presc       <= us_tick_c ? '0 : presc + PW'(1);
      frame_start <= commit_c;
      if (us_tick_c) us_cnt <= commit_c ? '0 : us_cnt + CW'(1);
      for (int i = 0; i < CH; i++) begin
        if (pos_valid) shadow[i] <= load_val[i];
        if (commit_c)  width[i]  <= width_next[i];
        pwm[i] <= enable && (MW'(us_cnt) < MW'(width[i]));
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Random-stimulus bench: a time-indexed model predicts per-frame high-time of every
// channel for an unlimited-slew and a slew-limited instance; a monitor compares per frame.
module tb_servo_pwm_array;
  localparam int CH       = 3;
  localparam int IN_W     = 10;
  localparam int CLK_HZ   = 2_000_000;
  localparam int DIV      = 2;
  localparam int FRAME_US = 2500;
  localparam int FCYC     = DIV * FRAME_US;
  localparam logic [CH-1:0] INV = 3'b010;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pos_valid = 1'b0;
  logic              enable = 1'b1;
  logic [CH*IN_W-1:0] pos_in = '0;
  logic [CH-1:0]     pwm0, pwm1;
  logic              fs0, fs1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_array #(.CH(CH), .IN_W(IN_W), .CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US),
                    .SLEW_US(0), .INV_MASK(INV)) dut0 (
    .clk(clk), .rst(rst), .pos_in(pos_in), .pos_valid(pos_valid),
    .enable(enable), .pwm(pwm0), .frame_start(fs0));

  servo_pwm_array #(.CH(CH), .IN_W(IN_W), .CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US),
                    .SLEW_US(100), .INV_MASK(INV)) dut1 (
    .clk(clk), .rst(rst), .pos_in(pos_in), .pos_valid(pos_valid),
    .enable(enable), .pwm(pwm1), .frame_start(fs1));

  // Reference model state: t = clock edges since reset release, widths in us.
  int t;
  int s [CH];
  int w [2][CH];
  int acc [2][CH];
  int q [$];

  function automatic bit commit_at(input int tt);
    return ((tt % DIV) == DIV - 1) && (((tt / DIV) % FRAME_US) == FRAME_US - 1);
  endfunction

  function automatic int target_us(input int code, input int ch);
    int v;
    v = 1000 + (INV[ch] ? (1023 - code) : code);
    if (v < 1000) v = 1000;
    if (v > 2000) v = 2000;
    return v;
  endfunction

  always @(posedge clk) begin : model
    int us, sl, diff, code;
    if (rst) begin
      t = 0;
      for (int i = 0; i < CH; i++) begin
        s[i] = 1500;
        for (int d = 0; d < 2; d++) begin
          w[d][i] = 1500;
          acc[d][i] = 0;
        end
      end
    end else begin
      us = (t / DIV) % FRAME_US;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < CH; i++)
          if (enable && us < w[d][i]) acc[d][i]++;
      if (commit_at(t)) begin
        for (int d = 0; d < 2; d++) begin
          sl = (d == 0) ? 0 : 100;
          for (int i = 0; i < CH; i++) begin
            q.push_back(acc[d][i]);
            acc[d][i] = 0;
            diff = s[i] - w[d][i];
            if (sl == 0 || (diff <= sl && diff >= -sl)) w[d][i] = s[i];
            else if (diff > 0) w[d][i] += sl;
            else w[d][i] -= sl;
          end
        end
      end
      if (pos_valid)
        for (int i = 0; i < CH; i++) begin
          code = int'(pos_in[i*IN_W +: IN_W]);
          s[i] = target_us(code, i);
        end
      t++;
    end
  end

  // Monitor: count high cycles per channel, compare against the model at each frame_start.
  int cnt [2][CH];
  always @(posedge clk) begin : monitor
    int exp_v;
    #1;
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < CH; i++) cnt[d][i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt[0][i] += int'(pwm0[i]);
        cnt[1][i] += int'(pwm1[i]);
      end
      if (fs0 || fs1 || q.size() != 0) begin
        checks++;
        if (!(fs0 && fs1) || q.size() < 2 * CH) begin
          failures++;
          $display("FAIL frame_start fs0=%0b fs1=%0b queued=%0d t=%0d", fs0, fs1, q.size(), t);
          q.delete();
        end else begin
          for (int d = 0; d < 2; d++)
            for (int i = 0; i < CH; i++) begin
              exp_v = q.pop_front();
              checks++;
              if (cnt[d][i] != exp_v) begin
                failures++;
                $display("FAIL high_cycles dut%0d ch%0d got=%0d exp=%0d t=%0d",
                         d, i, cnt[d][i], exp_v, t);
              end
            end
        end
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < CH; i++) cnt[d][i] = 0;
      end
    end
  end

  task automatic check_bits(input string name, input logic [CH*2:0] got, input logic [CH*2:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp_v);
    end
  endtask

  task automatic strobe(input int c0, input int c1, input int c2);
    pos_in = {IN_W'(c2), IN_W'(c1), IN_W'(c0)};
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  // Wait until the next edge is the first cycle of microsecond us_target.
  task automatic wait_us(input int us_target);
    int n;
    n = 0;
    while (!(((t % DIV) == 0) && (((t / DIV) % FRAME_US) == us_target)) && n < FCYC + 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= FCYC + 10) begin
      checks++;
      failures++;
      $display("FAIL wait_us target=%0d timed out", us_target);
    end
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    while (!commit_at(t) && n < FCYC + 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= FCYC + 10) begin
      checks++;
      failures++;
      $display("FAIL wait_commit timed out");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_bits("reset_state", {fs0, pwm1, pwm0}, '0);
    check_bits("reset_fs1", {6'b0, fs1}, '0);
    rst = 1'b0;
    @(negedge clk);
    check_bits("release_rise", {1'b0, pwm1, pwm0}, {1'b0, 6'b111111});
    check_bits("no_fs_at_release", {6'b0, fs0 | fs1}, '0);
    repeat (2 * FCYC) @(negedge clk);

    // Extreme codes; slew-limited instance walks 1500 -> 1000 / 2000 in 100 us steps.
    wait_us(700);
    strobe(0, 0, 1023);
    repeat (6 * FCYC) @(negedge clk);

    // Strobe landing exactly on the commit cycle is deferred one frame.
    wait_commit();
    strobe(200, 0, 1023);
    repeat (2 * FCYC + 20) @(negedge clk);

    // Enable gap mid-frame.
    wait_us(500);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_bits("enable_off", {1'b0, pwm1, pwm0}, '0);
    repeat (1997) @(negedge clk);
    check_bits("enable_off_end", {1'b0, pwm1, pwm0}, '0);
    enable = 1'b1;
    repeat (FCYC + 100) @(negedge clk);

    // Reset mid-frame discards a pending shadow update.
    strobe(900, 50, 300);
    wait_us(1700);
    rst = 1'b1;
    @(negedge clk);
    check_bits("midframe_reset", {fs0 | fs1, pwm1, pwm0}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FCYC) @(negedge clk);

    // Random strobes and enable toggles.
    for (int k = 0; k < 2 * FCYC; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 799) == 0)
        strobe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
    end
    enable = 1'b1;
    repeat (FCYC + 20) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
